// File: rtl/lcd_read_engine.sv
// rtl/lcd_read_engine.sv - HD44780 4-bit read-cycle sequencer: two E pulses, nibble capture, byte assembly.
// Optional busy-flag polling is enabled by defining LCD_READ_POLL_EN.
module lcd_read_engine #(
    parameter int SETUP_CYCLES = 3,
    parameter int PULSE_CYCLES = 12,
    parameter int SAMPLE_CYCLE = 9,
    parameter int GAP_CYCLES   = 50,
    parameter int HOLD_CYCLES  = 2
`ifdef LCD_READ_POLL_EN
    ,
    parameter int MAX_POLLS    = 255
`endif
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iStart,
    input  logic       iRS,
    input  logic [3:0] iLCD_Data,
`ifdef LCD_READ_POLL_EN
    input  logic       iPoll,
    output logic       oTimeout,
`endif
    output logic       oLCD_RS,
    output logic       oLCD_RW,
    output logic       oLCD_E,
    output logic       oBusOwn,
    output logic       oReady,
    output logic [7:0] oReadData,
    output logic       oBusyFlag,
    output logic       oReadDone
);
    typedef enum logic [2:0] {IDLE, SETUP1, PULSE1, GAP, PULSE2, HOLD, DONE} state_t;

    state_t     state, state_next;
    logic [7:0] cnt;
    logic       rs_q;
    logic [3:0] hi, lo;
    logic       sample_hi, sample_lo;

`ifdef LCD_READ_POLL_EN
    logic       poll_mode;
    logic       timeout_q;
    logic [7:0] poll_cnt;
    logic       poll_again;

    assign poll_again = poll_mode && hi[3] && (poll_cnt != 8'(MAX_POLLS - 1));
`endif

    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (iStart) state_next = SETUP1;
            SETUP1: if (cnt == 8'(SETUP_CYCLES - 1)) state_next = PULSE1;
            PULSE1: if (cnt == 8'(PULSE_CYCLES - 1)) state_next = GAP;
            GAP:    if (cnt == 8'(GAP_CYCLES - 1))   state_next = PULSE2;
            PULSE2: if (cnt == 8'(PULSE_CYCLES - 1)) state_next = HOLD;
            HOLD: begin
                if (cnt == 8'(HOLD_CYCLES - 1)) begin
`ifdef LCD_READ_POLL_EN
                    state_next = poll_again ? SETUP1 : DONE;
`else
                    state_next = DONE;
`endif
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus outputs follow the registered state one clock later, so RS/RW/E move together
    // and E can only be high while the bus is owned.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt       <= 8'd0;
            rs_q      <= 1'b0;
            hi        <= 4'h0;
            lo        <= 4'h0;
            sample_hi <= 1'b0;
            sample_lo <= 1'b0;
            oLCD_RS   <= 1'b0;
            oLCD_RW   <= 1'b0;
            oLCD_E    <= 1'b0;
            oBusOwn   <= 1'b0;
            oReady    <= 1'b1;
            oReadData <= 8'h00;
            oBusyFlag <= 1'b0;
            oReadDone <= 1'b0;
        end else begin
            cnt <= (state_next != state || state == IDLE) ? 8'd0 : cnt + 8'd1;
            if (state == IDLE && iStart) rs_q <= iRS;
            // One-cycle delay aligns the capture strobe with the visible E-high cycle count.
            sample_hi <= (state == PULSE1) && (cnt == 8'(SAMPLE_CYCLE - 1));
            sample_lo <= (state == PULSE2) && (cnt == 8'(SAMPLE_CYCLE - 1));
            if (sample_hi) hi <= iLCD_Data;
            if (sample_lo) lo <= iLCD_Data;
            oLCD_E    <= (state == PULSE1) || (state == PULSE2);
            oLCD_RW   <= (state != IDLE);
            oBusOwn   <= (state != IDLE);
            oLCD_RS   <= (state != IDLE) && rs_q;
            oReady    <= (state_next == IDLE);
            oReadDone <= (state == DONE);
            if (state == DONE) begin
                oReadData <= {hi, lo};
                oBusyFlag <= !rs_q && hi[3];
            end
        end
    end

`ifdef LCD_READ_POLL_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            poll_mode <= 1'b0;
            timeout_q <= 1'b0;
            poll_cnt  <= 8'd0;
            oTimeout  <= 1'b0;
        end else begin
            oTimeout <= (state == DONE) && timeout_q;
            if (state == IDLE && iStart) begin
                poll_mode <= iPoll && !iRS;
                timeout_q <= 1'b0;
                poll_cnt  <= 8'd0;
            end else if (state == HOLD && state_next == SETUP1) begin
                poll_cnt <= poll_cnt + 8'd1;
            end else if (state == HOLD && state_next == DONE && poll_mode && hi[3]) begin
                timeout_q <= 1'b1;
            end
        end
    end
`endif
endmodule

// File: doc/lcd_read_engine.md
Name: lcd_read_engine

Overview:
- Generates the HD44780 read-cycle timing on the Spartan-3E 4-bit character-LCD bus. It is the read-side counterpart of the LCD write-enable pulse generator.
- One request performs two E pulses: high nibble, then low nibble. Each nibble is sampled from the LCD data lines, and the block returns the assembled byte.
- A read with RS=0 returns the busy flag and address counter. A read with RS=1 returns data from CGRAM/DDRAM.
- Sits beside the write path. The top-level bus mux hands RS/RW/E and data-line tristate control to this block while oBusOwn is high.

Parameters:
- SETUP_CYCLES, 3, clocks RS/RW are held stable with E=0 before each E rise (>=40 ns at 50 MHz).
- PULSE_CYCLES, 12, clocks E is held high per nibble (240 ns).
- SAMPLE_CYCLE, 9, which E-high clock (1-based) samples iLCD_Data (180 ns, past tDDR). Must satisfy 1 <= SAMPLE_CYCLE <= PULSE_CYCLES.
- GAP_CYCLES, 50, clocks E is low between the two nibble pulses (1 us).
- HOLD_CYCLES, 2, clocks RS/RW are held after the final E fall.

Ports:
- Clock  input  1  system clock, 50 MHz.
- Reset  input  1  synchronous, active-high.
- iStart  input  1  request a read; sampled only when oReady=1.
- iRS  input  1  register select for the read; latched with iStart.
- iLCD_Data  input  4  LCD data lines SF_D[11:8].
- oLCD_RS  output  1  LCD register select.
- oLCD_RW  output  1  LCD read/write; 1 = read.
- oLCD_E  output  1  LCD enable.
- oBusOwn  output  1  block owns the LCD bus; the top level must tristate the data lines.
- oReady  output  1  idle; accepts iStart.
- oReadData  output  8  last byte read: {high nibble, low nibble}.
- oBusyFlag  output  1  oReadData[7] when the last read had RS=0; 0 otherwise.
- oReadDone  output  1  single-cycle pulse when oReadData is updated.

Behaviour:
- Reset values: RS=0, RW=0, E=0, BusOwn=0, Ready=1, ReadData=8'h00, BusyFlag=0, ReadDone=0. The phase counter is cleared.
- All outputs are registered. Reset asserted mid-read returns the block to IDLE at the next edge: E drops immediately, any partial nibble is discarded, oReadDone is not pulsed.
- State machine, with durations in clock cycles:
  - IDLE: Ready=1, BusOwn=0, RW=0, E=0. On iStart=1, latch iRS and go to SETUP1.
  - SETUP1 (SETUP_CYCLES): BusOwn=1, RW=1, RS=latched, E=0, Ready=0.
  - PULSE1 (PULSE_CYCLES): E=1. On the SAMPLE_CYCLE-th cycle, capture iLCD_Data into the high-nibble register.
  - GAP (GAP_CYCLES): E=0, RS/RW held.
  - PULSE2 (PULSE_CYCLES): E=1. On the SAMPLE_CYCLE-th cycle, capture the low nibble.
  - HOLD (HOLD_CYCLES): E=0, RS/RW held.
  - DONE (1 cycle): oReadData <= {hi, lo}; oBusyFlag <= latched RS==0 ? hi[3] : 0; oReadDone=1. BusOwn=1, RW=1.
  - Then IDLE: RW=0, BusOwn=0.
- Counter:
  - Cleared on every state entry.
  - A state exits when counter == duration-1.
  - Width is 8 bits; it never wraps with legal parameters.
- Latency with defaults: iStart sampled at edge T0; E first rises at T0+4; oReadDone is high in cycle T0+80. The next iStart is accepted at T0+81.
- iStart while Ready=0 is ignored, not queued. iRS changes after the latch have no effect.
- RS and RW never change while E=1. E is never high while BusOwn=0.
- oReadData and oBusyFlag hold their values between reads.

Optional Feature:
- Macro LCD_READ_POLL_EN.
- When defined:
  - Extra input iPoll (1) and output oTimeout (1) exist, plus parameter MAX_POLLS (default 255).
  - If iStart is accepted with iPoll=1 and iRS=0, then after each HOLD with hi[3]=1, the block re-enters SETUP1 instead of DONE. No oReadDone is pulsed for intermediate reads.
  - Polling stops on the first read with BF=0, which goes to DONE normally.
  - After MAX_POLLS reads with BF still 1, the block goes to DONE with oTimeout=1 for that DONE cycle and oBusyFlag=1.
  - oTimeout resets to 0.
- When undefined: no iPoll/oTimeout ports; every request is a single read.

Test Plan:
- Reset, then iStart=1 with iRS=0, and iLCD_Data=4'h8 during pulse 1 and 4'h3 during pulse 2 -> oReadDone at T0+80, oReadData=8'h83, oBusyFlag=1, RW=1 throughout, E high exactly 12 cycles twice.
- iRS=1, data nibbles 4'h4 then 4'h1 -> oReadData=8'h41, oBusyFlag=0, RS=1 from T0+1 to T0+80.
- iLCD_Data changes on E-high cycle 10 of a pulse -> the value present on cycle 9 is captured.
- iStart pulsed at T0+20 during a read -> ignored; only one oReadDone; next accepted iStart at T0+81 starts a new read.
- Reset asserted at T0+30 (during GAP) -> E=0, BusOwn=0, Ready=1 next cycle, oReadData=8'h00, no oReadDone.
- With LCD_READ_POLL_EN and MAX_POLLS=3, iPoll=1, BF=1 on reads 1-2 and 0 on read 3 -> one oReadDone at T0+1+3*79, oTimeout=0. With BF always 1 -> oTimeout=1 after the 3rd read.
